// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
// Module      : tick_divider
// Description : Bank of NCH independent programmable tick dividers. Each
//               channel counts 0..P-1 on the system clock and emits a
//               one-cycle tick plus a toggling square wave at every wrap.
//               A shadow/active period pair lets software change the period
//               without disturbing the cycle in progress.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NCH    : number of channels (1..16)
//   CNT_W  : width of each period register and counter
// Ports
//   CLK    : system clock, all state updates on its rising edge
//   RESET  : asynchronous active-low reset
//   period : per-channel period, channel i at [i*CNT_W +: CNT_W]
//   load   : per-channel strobe, captures the period slice into the shadow
//   en     : per-channel run enable (level)
//   sync   : global restart strobe (only acts when TICKDIV_SYNC_EN defined)
//   o_tick : per-channel one-cycle pulse after each wrap edge
//   o_lclk : per-channel square wave, inverts on each wrap edge
// Configuration macro
//   TICKDIV_SYNC_EN : when defined, sync=1 restarts every channel in phase
// ============================================================================
module tick_divider #(
    parameter int NCH   = 4,
    parameter int CNT_W = 32
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [NCH*CNT_W-1:0] period,
    input  logic [NCH-1:0]       load,
    input  logic [NCH-1:0]       en,
    input  logic                 sync,
    output logic [NCH-1:0]       o_tick,
    output logic [NCH-1:0]       o_lclk
);

    localparam logic [CNT_W-1:0] c_zero = '0;
    localparam logic [CNT_W-1:0] c_one  = {{(CNT_W-1){1'b0}}, 1'b1};

`ifndef TICKDIV_SYNC_EN
    // The port stays on the boundary so both builds share one footprint,
    // but nothing inside consumes it.
    logic w_unused_sync;
    assign w_unused_sync = sync;
`endif

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [CNT_W-1:0] r_shadow;
        logic [CNT_W-1:0] r_active;
        logic [CNT_W-1:0] r_cnt;
        logic             r_tick;
        logic             r_lclk;
        logic [CNT_W-1:0] w_slice;
        logic             w_run;
        logic             w_wrap;

        assign w_slice = period[gi*CNT_W +: CNT_W];
        // A zero active period parks the channel; the wrap compare is
        // qualified so P-1 never underflows into a huge terminal count.
        assign w_run   = (r_active != c_zero);
        assign w_wrap  = w_run && (r_cnt == (r_active - c_one));

        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                r_shadow <= c_zero;
            end else if (load[gi]) begin
                r_shadow <= w_slice;
            end
        end

        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                r_active <= c_zero;
                r_cnt    <= c_zero;
                r_tick   <= 1'b0;
                r_lclk   <= 1'b0;
            end
`ifdef TICKDIV_SYNC_EN
            // Restart wins over wrap and over the load bypass so that every
            // channel leaves this edge at count 0 with its shadow period.
            else if (sync) begin
                r_active <= r_shadow;
                r_cnt    <= c_zero;
                r_tick   <= 1'b0;
                r_lclk   <= 1'b0;
            end
`endif
            else if (!en[gi]) begin
                // Idle channels keep tracking the shadow so the first period
                // after enabling is the most recently loaded one.
                r_active <= r_shadow;
                r_cnt    <= c_zero;
                r_tick   <= 1'b0;
                r_lclk   <= 1'b0;
            end else if (!w_run) begin
                // Halted: square wave freezes at its current level.
                r_active <= r_shadow;
                r_cnt    <= c_zero;
                r_tick   <= 1'b0;
            end else if (w_wrap) begin
                // A load landing on the wrap edge takes effect immediately
                // rather than waiting a full extra period in the shadow.
                r_active <= load[gi] ? w_slice : r_shadow;
                r_cnt    <= c_zero;
                r_tick   <= 1'b1;
                r_lclk   <= ~r_lclk;
            end else begin
                r_cnt    <= r_cnt + c_one;
                r_tick   <= 1'b0;
            end
        end

        assign o_tick[gi] = r_tick;
        assign o_lclk[gi] = r_lclk;
    end

endmodule
`default_nettype wire

// File: tb/tb_tick_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_divider
// Description : Self-checking bench for tick_divider. A countdown-style
//               reference model (cycles remaining until the next tick) is
//               advanced on every rising edge and compared with o_tick and
//               o_lclk shortly after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_divider;

    localparam int NCH = 4;
    localparam int CW  = 8;

`ifdef TICKDIV_SYNC_EN
    localparam bit SYNC_ON = 1'b1;
`else
    localparam bit SYNC_ON = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RESET;
    logic [NCH*CW-1:0] period;
    logic [NCH-1:0]    load;
    logic [NCH-1:0]    en;
    logic              sync;
    logic [NCH-1:0]    o_tick;
    logic [NCH-1:0]    o_lclk;

    tick_divider #(.NCH(NCH), .CNT_W(CW)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .period (period),
        .load   (load),
        .en     (en),
        .sync   (sync),
        .o_tick (o_tick),
        .o_lclk (o_lclk)
    );

    always #5 CLK = ~CLK;

    // Reference model state: m_left counts edges remaining in the current
    // period (0 = a fresh period begins at the next running edge).
    int unsigned m_sh   [NCH];
    int unsigned m_act  [NCH];
    int unsigned m_left [NCH];
    bit          m_tick [NCH];
    bit          m_lclk [NCH];

    int n_vec = 0;
    int n_err = 0;
    int tick_cnt [NCH];

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_sh[i] = 0; m_act[i] = 0; m_left[i] = 0;
            m_tick[i] = 1'b0; m_lclk[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < NCH; i++) begin
            int unsigned slice;
            int unsigned old_sh;
            slice  = int'(period[i*CW +: CW]);
            old_sh = m_sh[i];
            if (load[i]) m_sh[i] = slice;
            if ((SYNC_ON && sync) || !en[i]) begin
                m_act[i] = old_sh; m_left[i] = 0;
                m_tick[i] = 1'b0; m_lclk[i] = 1'b0;
            end else if (m_act[i] == 0) begin
                m_act[i] = old_sh; m_left[i] = 0; m_tick[i] = 1'b0;
            end else begin
                if (m_left[i] == 0) m_left[i] = m_act[i];
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) begin
                    m_tick[i] = 1'b1;
                    m_lclk[i] = ~m_lclk[i];
                    m_act[i]  = load[i] ? slice : old_sh;
                end else begin
                    m_tick[i] = 1'b0;
                end
            end
        end
    endtask

    function automatic int unsigned model_cnt(int ch);
        return (m_left[ch] == 0) ? 0 : m_act[ch] - m_left[ch];
    endfunction

    task automatic check(string tag);
        logic [NCH-1:0] et, el;
        for (int i = 0; i < NCH; i++) begin
            et[i] = m_tick[i];
            el[i] = m_lclk[i];
        end
        n_vec++;
        assert (o_tick === et && o_lclk === el) else begin
            n_err++;
            $error("FAIL %s t=%0t tick=%b exp=%b lclk=%b exp=%b",
                   tag, $time, o_tick, et, o_lclk, el);
        end
    endtask

    task automatic step(string tag);
        @(posedge CLK);
        if (RESET) model_edge();
        #1;
        check(tag);
        for (int i = 0; i < NCH; i++) if (o_tick[i]) tick_cnt[i]++;
    endtask

    task automatic set_p(int ch, int unsigned v);
        logic [CW-1:0] s;
        s = v[CW-1:0];
        period[ch*CW +: CW] = s;
    endtask

    task automatic expect_cond(bit cond, string tag);
        n_vec++;
        assert (cond) else begin
            n_err++;
            $error("FAIL %s bound expired t=%0t", tag, $time);
        end
    endtask

    initial begin
        RESET = 1'b0; period = '0; load = '0; en = '0; sync = 1'b0;
        model_reset();

        // Reset held: inputs thrash, outputs must stay low.
        repeat (20) begin
            period = {$urandom, $urandom};
            load = NCH'($urandom); en = NCH'($urandom); sync = 1'($urandom);
            step("rst_hold");
        end
        load = '0; sync = 1'b0; en = '1; period = '0;
        RESET = 1'b1;
        repeat (1000) step("idle_no_load");

        // Basic: period 4 on ch0.
        en = '0; step("basic_prep");
        set_p(0, 4); load = 4'b0001; step("basic_load");
        load = '0; step("basic_copy");
        en = 4'b0001;
        for (int i = 0; i < NCH; i++) tick_cnt[i] = 0;
        repeat (40) step("basic_p4");
        n_vec++;
        assert (tick_cnt[0] == 10) else begin
            n_err++; $error("FAIL basic_count got=%0d exp=10", tick_cnt[0]);
        end

        // Boundaries: P=1, then P=0 (halt), then P=3.
        en = '0; set_p(0, 1); load = 4'b0001; step("p1_load");
        load = '0; step("p1_copy");
        en = 4'b0001; repeat (10) step("p1_run");
        set_p(0, 0); load = 4'b0001; step("p0_load");
        load = '0; repeat (10) step("p0_halt");
        set_p(0, 3); load = 4'b0001; step("p3_load");
        load = '0; repeat (15) step("p3_run");

        // Reload: 10 running, load 5 at count 2, then load 7 on a wrap edge.
        set_p(0, 10); load = 4'b0001; step("r10_load");
        load = '0;
        for (int k = 0; k < 40 && !(m_act[0] == 10 && model_cnt(0) == 2); k++)
            step("r10_seek");
        expect_cond(m_act[0] == 10 && model_cnt(0) == 2, "r10_seek");
        set_p(0, 5); load = 4'b0001; step("r5_load");
        load = '0; repeat (25) step("r5_run");
        for (int k = 0; k < 10 && !(m_act[0] == 5 && model_cnt(0) == 4); k++)
            step("r5_seek");
        expect_cond(m_act[0] == 5 && model_cnt(0) == 4, "r5_seek");
        set_p(0, 7); load = 4'b0001; step("r7_bypass");
        load = '0; repeat (25) step("r7_run");

        // Independent channels at 2,3,5,7 over 420 cycles.
        en = '0;
        set_p(0, 2); set_p(1, 3); set_p(2, 5); set_p(3, 7);
        load = '1; step("ch_load");
        load = '0; step("ch_copy");
        en = '1;
        for (int i = 0; i < NCH; i++) tick_cnt[i] = 0;
        repeat (420) step("ch_run");
        n_vec++;
        assert (tick_cnt[0] == 210 && tick_cnt[1] == 140 &&
                tick_cnt[2] == 84 && tick_cnt[3] == 60) else begin
            n_err++;
            $error("FAIL ch_counts got=%0d,%0d,%0d,%0d exp=210,140,84,60",
                   tick_cnt[0], tick_cnt[1], tick_cnt[2], tick_cnt[3]);
        end
        en[2] = 1'b0; repeat (15) step("ch2_off");
        en[2] = 1'b1; repeat (30) step("ch2_on");

        // Sync with periods 3 and 6 in flight.
        en = '0;
        set_p(0, 3); set_p(1, 6); set_p(2, 4); set_p(3, 5);
        load = '1; step("sync_load");
        load = '0; step("sync_copy");
        en = '1; repeat (7) step("sync_pre");
        sync = 1'b1; step("sync_pulse");
        sync = 1'b0; repeat (24) step("sync_post");

        // Largest legal period for this width.
        en = '0; set_p(0, 255); load = 4'b0001; step("pmax_load");
        load = '0; step("pmax_copy");
        en = 4'b0001; repeat (520) step("pmax_run");

        // Randomised traffic.
        en = '1;
        repeat (2000) begin
            for (int i = 0; i < NCH; i++)
                set_p(i, ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 9));
            for (int i = 0; i < NCH; i++) begin
                load[i] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 29) == 0) en[i] = ~en[i];
            end
            sync = ($urandom_range(0, 49) == 0);
            step("random");
        end
        load = '0; sync = 1'b0;

        // Asynchronous reset mid-count, checked before any further edge.
        #2 RESET = 1'b0;
        model_reset();
        #1 check("async_rst");
        repeat (3) step("rst_mid");
        RESET = 1'b1; en = '1;
        repeat (30) step("post_rst_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tick_divider.md
TICK_DIVIDER -- requirements
Module: tick_divider

Interface
REQ-001 Parameter NCH, default 4: number of independent divider channels, range 1..16.
REQ-002 Parameter CNT_W, default 32: width of each channel period and counter.
REQ-003 Port CLK  input  1: single system clock; all state on its rising edge.
REQ-004 Port RESET  input  1: asynchronous, active-low reset.
REQ-005 Port period  input  NCH*CNT_W: per-channel period value; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-006 Port load  input  NCH: per-channel one-cycle strobe that captures the channel's period slice into its shadow register.
REQ-007 Port en  input  NCH: per-channel run enable, level-sensitive.
REQ-008 Port sync  input  1: global counter restart strobe, active high; its effect is defined under Configuration.
REQ-009 Port o_tick  output  NCH: per-channel registered one-cycle pulse at each terminal count.
REQ-010 Port o_lclk  output  NCH: per-channel registered square wave that toggles on every tick.

Function
REQ-011 Each channel SHALL hold a shadow period register, an active period register and a CNT_W-bit counter, all independent of the other channels.
REQ-012 A load strobe SHALL write the channel's period slice into its shadow register on that edge.
REQ-013 The active period SHALL copy the shadow period on the wrap edge, whenever en is low, and whenever the active period is 0.
REQ-014 If load coincides with a wrap edge, the new period input value SHALL bypass the shadow and become the active period on that same edge.
REQ-015 While the channel is enabled with active period P>0, the counter SHALL count 0..P-1, then wrap to 0; the wrap edge is the edge at which the counter equals P-1.
REQ-016 o_tick[i] SHALL be high for exactly one cycle following each wrap edge; P=1 gives o_tick held continuously high.
REQ-017 o_lclk[i] SHALL invert on each wrap edge, giving a period of 2P cycles and a 50% duty cycle.
REQ-018 The first o_tick SHALL appear after the P-th rising edge following the edge that first samples en[i]=1.
REQ-019 With en[i] low, the counter, o_tick[i] and o_lclk[i] SHALL be forced to 0 on the next edge.
REQ-020 An active period of 0 SHALL halt the channel: counter held at 0, o_tick 0, o_lclk holding its value; the channel resumes after a nonzero value is loaded.
REQ-021 A period change SHALL never truncate or extend the cycle in progress, except for the bypass case in REQ-014.
REQ-022 The counter SHALL never exceed P-1, and all period arithmetic SHALL be unsigned CNT_W-bit; P=2^CNT_W-1 is legal.

Reset
REQ-023 While RESET is low, all shadow periods, active periods, counters, o_tick and o_lclk SHALL be 0, with no clock required.
REQ-024 After RESET releases, no channel SHALL tick until a nonzero period has been loaded and en is high.
REQ-025 A reset asserted mid-count SHALL discard all state; no partial tick SHALL be emitted.

Configuration
REQ-026 Macro TICKDIV_SYNC_EN, when defined, SHALL make sync=1 on an edge do the following for every channel on that edge:
- clear the counter to 0;
- clear o_tick and o_lclk to 0;
- copy the shadow period into the active period.
REQ-027 When TICKDIV_SYNC_EN is defined, sync SHALL take priority over wrap and over the bypass in REQ-014, and the channels SHALL then run phase-aligned.
REQ-028 When TICKDIV_SYNC_EN is undefined, sync SHALL be ignored and no sync logic SHALL be synthesised; the port remains present.

Verification
REQ-029 Reset: hold RESET low, toggle all inputs -> o_tick=0 and o_lclk=0 throughout; release with en=all ones and no load -> no ticks for 1000 cycles.
REQ-030 Basic: load ch0 period 4, set en[0]=1 -> o_tick[0] pulses every 4 cycles, first after the 4th edge; o_lclk[0] has period 8.
REQ-031 Boundary: period 1 -> o_tick continuously high, o_lclk toggles every cycle; period 0 -> halted; then load 3 -> ticks every 3 cycles.
REQ-032 Reload: with period 10 running, load 5 at count 2 -> the current cycle completes at 10, then ticks every 5; load coincident with wrap -> the new period applies immediately.
REQ-033 Channels: ch0..ch3 at periods 2, 3, 5, 7 -> correct independent tick rates over 420 cycles, each channel ending at an exact multiple; dropping en[2] mid-run affects only ch2.
REQ-034 Sync (with TICKDIV_SYNC_EN): pulse sync with periods 3 and 6 running -> both counters restart and ticks coincide every 6 cycles; without the macro, sync has no effect.
